// File: rtl/multicycle_control_pkg.sv
// Shared constants for the multicycle controller: opcode/funct codes, FSM states,
// instruction classes and the pc_src / mem_to_reg / reg_dst / alu_src_b encodings.
package multicycle_control_pkg;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ADDIU = 6'h09;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_SLTIU = 6'h0B;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_SLL   = 6'h00;
   localparam logic [5:0] FN_SRL   = 6'h02;
   localparam logic [5:0] FN_SRA   = 6'h03;
   localparam logic [5:0] FN_JR    = 6'h08;
   localparam logic [5:0] FN_JALR  = 6'h09;
   localparam logic [5:0] FN_MFHI  = 6'h10;
   localparam logic [5:0] FN_MFLO  = 6'h12;
   localparam logic [5:0] FN_MULT  = 6'h18;
   localparam logic [5:0] FN_MULTU = 6'h19;
   localparam logic [5:0] FN_DIV   = 6'h1A;
   localparam logic [5:0] FN_DIVU  = 6'h1B;
   localparam logic [5:0] FN_ADD   = 6'h20;
   localparam logic [5:0] FN_ADDU  = 6'h21;
   localparam logic [5:0] FN_SUB   = 6'h22;
   localparam logic [5:0] FN_SUBU  = 6'h23;
   localparam logic [5:0] FN_AND   = 6'h24;
   localparam logic [5:0] FN_OR    = 6'h25;
   localparam logic [5:0] FN_XOR   = 6'h26;
   localparam logic [5:0] FN_NOR   = 6'h27;
   localparam logic [5:0] FN_SLT   = 6'h2A;
   localparam logic [5:0] FN_SLTU  = 6'h2B;

   typedef enum logic [2:0] {
      ST_FETCH       = 3'd0,
      ST_DECODE      = 3'd1,
      ST_EXEC        = 3'd2,
      ST_MEM         = 3'd3,
      ST_WB          = 3'd4,
      ST_MULDIV_WAIT = 3'd5
   } state_t;

   typedef enum logic [3:0] {
      CLS_ILLEGAL,
      CLS_ALU_R,
      CLS_ALU_I,
      CLS_LOAD,
      CLS_STORE,
      CLS_BRANCH,
      CLS_JUMP,
      CLS_JAL,
      CLS_JR,
      CLS_JALR,
      CLS_MULDIV,
      CLS_MFHILO
   } instr_class_t;

   localparam logic [1:0] PC_SRC_SEQ    = 2'b00;
   localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
   localparam logic [1:0] PC_SRC_JUMP   = 2'b10;
   localparam logic [1:0] PC_SRC_REG    = 2'b11;

   localparam logic [1:0] M2R_ALU  = 2'd0;
   localparam logic [1:0] M2R_MEM  = 2'd1;
   localparam logic [1:0] M2R_LINK = 2'd2;
   localparam logic [1:0] M2R_HILO = 2'd3;

   localparam logic [1:0] REG_DST_RT = 2'd0;
   localparam logic [1:0] REG_DST_RD = 2'd1;
   localparam logic [1:0] REG_DST_RA = 2'd2;

   localparam logic [1:0] SRC_B_REG    = 2'd0;
   localparam logic [1:0] SRC_B_FOUR   = 2'd1;
   localparam logic [1:0] SRC_B_IMM    = 2'd2;
   localparam logic [1:0] SRC_B_BRANCH = 2'd3;

   localparam int WAIT_CNT_W = 5;

   typedef struct packed {
      instr_class_t cls;
      logic         shift;
      logic         ext_op;
      logic         lu_op;
      logic [3:0]   alu_op;
   } decode_t;

   function automatic logic writes_rd(input instr_class_t cls);
      return (cls == CLS_ALU_R) || (cls == CLS_MFHILO);
   endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Control bundle between the multicycle controller (master) and the datapath (slave).
interface multicycle_control_if #(
   parameter int ALUOP_W = 4
);
   // mem_read/mem_write are requests held by the controller; the access completes
   // in the cycle where mem_ready is high at the rising edge, and only then does the FSM advance.
   logic [5:0]         opcode;
   logic [5:0]         funct;
   logic               mem_ready;

   logic               pc_write;
   logic               pc_write_cond;
   logic               ir_write;
   logic               i_or_d;
   logic               reg_write;
   logic [1:0]         reg_dst;
   logic [1:0]         mem_to_reg;
   logic [1:0]         pc_src;

   logic               mem_read;
   logic               mem_write;
   logic               alu_src_a;
   logic [1:0]         alu_src_b;
   logic               ext_op;
   logic               lu_op;
   logic [ALUOP_W-1:0] alu_op;

   logic               muldiv_start;
   logic               illegal_instr;
   logic               busy;
   logic [2:0]         state;

   modport master (
      input  opcode, funct, mem_ready,
      output pc_write, pc_write_cond, ir_write, i_or_d, reg_write, reg_dst, mem_to_reg, pc_src,
      output mem_read, mem_write, alu_src_a, alu_src_b, ext_op, lu_op, alu_op,
      output muldiv_start, illegal_instr, busy, state
   );

   modport slave (
      output opcode, funct, mem_ready,
      input  pc_write, pc_write_cond, ir_write, i_or_d, reg_write, reg_dst, mem_to_reg, pc_src,
      input  mem_read, mem_write, alu_src_a, alu_src_b, ext_op, lu_op, alu_op,
      input  muldiv_start, illegal_instr, busy, state
   );
endinterface

// File: rtl/multicycle_control_decode.sv
// mc_decode: combinational opcode/funct to instruction class and ALU control decoder.
// mult/multu/div/divu/mfhi/mflo are legal only when MULTICYCLE_MULDIV_EN is defined.
module mc_decode
   import multicycle_control_pkg::*;
(
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   output decode_t    dec
);

   logic [2:0] alu_lo;

   always_comb begin
      dec.cls    = CLS_ILLEGAL;
      dec.shift  = 1'b0;
      dec.ext_op = 1'b1;
      dec.lu_op  = 1'b0;
      alu_lo     = 3'b000;
      case (opcode)
         OP_RTYPE: begin
            alu_lo = 3'b010;
            case (funct)
               FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR,
               FN_XOR, FN_NOR, FN_SLT, FN_SLTU: dec.cls = CLS_ALU_R;
               FN_SLL, FN_SRL, FN_SRA: begin
                  dec.cls   = CLS_ALU_R;
                  dec.shift = 1'b1;
               end
               FN_JR:   dec.cls = CLS_JR;
               FN_JALR: dec.cls = CLS_JALR;
`ifdef MULTICYCLE_MULDIV_EN
               FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: dec.cls = CLS_MULDIV;
               FN_MFHI, FN_MFLO: dec.cls = CLS_MFHILO;
`endif
               default: dec.cls = CLS_ILLEGAL;
            endcase
         end
         OP_LW: dec.cls = CLS_LOAD;
         OP_SW: dec.cls = CLS_STORE;
         OP_BEQ: begin
            dec.cls = CLS_BRANCH;
            alu_lo  = 3'b001;
         end
         OP_ADDI, OP_ADDIU: dec.cls = CLS_ALU_I;
         OP_ANDI: begin
            dec.cls    = CLS_ALU_I;
            dec.ext_op = 1'b0;
            alu_lo     = 3'b100;
         end
         OP_SLTI: begin
            dec.cls = CLS_ALU_I;
            alu_lo  = 3'b101;
         end
         OP_SLTIU: begin
            dec.cls    = CLS_ALU_I;
            dec.ext_op = 1'b0;
            alu_lo     = 3'b101;
         end
         OP_LUI: begin
            dec.cls   = CLS_ALU_I;
            dec.lu_op = 1'b1;
         end
         OP_J:    dec.cls = CLS_JUMP;
         OP_JAL:  dec.cls = CLS_JAL;
         default: dec.cls = CLS_ILLEGAL;
      endcase
      // Bit 3 distinguishes signed/unsigned variants and comes straight from the opcode.
      dec.alu_op = {opcode[0], alu_lo};
   end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS-style controller FSM (FETCH/DECODE/EXEC/MEM/WB/MULDIV_WAIT).
// Optional mult/div support is enabled with the MULTICYCLE_MULDIV_EN macro.
module multicycle_control #(
   parameter int MULDIV_CYCLES = 4,
   parameter int ALUOP_W       = 4
) (
   input logic                  clk,
   input logic                  reset,
   multicycle_control_if.master ctl
);
   import multicycle_control_pkg::*;

   if (MULDIV_CYCLES < 1 || MULDIV_CYCLES > 32) begin : g_bad_cycles
      $error("MULDIV_CYCLES must be in 1..32");
   end
   if (ALUOP_W < 4) begin : g_bad_aluop
      $error("ALUOP_W must be at least 4");
   end

   state_t  state_q, state_d;
   decode_t dec;

   mc_decode u_decode (
      .opcode (ctl.opcode),
      .funct  (ctl.funct),
      .dec    (dec)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= ST_FETCH;
      else       state_q <= state_d;
   end

`ifdef MULTICYCLE_MULDIV_EN
   logic [WAIT_CNT_W-1:0] wait_cnt_q;
   logic                  wait_done;

   // Loaded with N-1 on entry so MULDIV_WAIT lasts exactly MULDIV_CYCLES cycles.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         wait_cnt_q <= '0;
      else if (state_q == ST_EXEC && dec.cls == CLS_MULDIV)
         wait_cnt_q <= WAIT_CNT_W'(MULDIV_CYCLES - 1);
      else if (state_q == ST_MULDIV_WAIT && wait_cnt_q != '0)
         wait_cnt_q <= wait_cnt_q - 1'b1;
   end

   assign wait_done = (wait_cnt_q == '0);
`endif

   assign ctl.state = state_q;

   // Reset gates every output so nothing is requested while the FSM is being forced.
   always_comb begin
      state_d           = ST_FETCH;
      ctl.pc_write      = 1'b0;
      ctl.pc_write_cond = 1'b0;
      ctl.ir_write      = 1'b0;
      ctl.i_or_d        = 1'b0;
      ctl.reg_write     = 1'b0;
      ctl.reg_dst       = REG_DST_RT;
      ctl.mem_to_reg    = M2R_ALU;
      ctl.pc_src        = PC_SRC_SEQ;
      ctl.mem_read      = 1'b0;
      ctl.mem_write     = 1'b0;
      ctl.alu_src_a     = 1'b0;
      ctl.alu_src_b     = SRC_B_REG;
      ctl.ext_op        = 1'b1;
      ctl.lu_op         = 1'b0;
      ctl.alu_op        = '0;
      ctl.muldiv_start  = 1'b0;
      ctl.illegal_instr = 1'b0;
      ctl.busy          = 1'b0;
      if (!reset) begin
         ctl.busy = (state_q != ST_FETCH);
         case (state_q)
            ST_FETCH: begin
               ctl.mem_read  = 1'b1;
               ctl.alu_src_b = SRC_B_FOUR;
               if (ctl.mem_ready) begin
                  ctl.ir_write = 1'b1;
                  ctl.pc_write = 1'b1;
                  state_d      = ST_DECODE;
               end else begin
                  state_d = ST_FETCH;
               end
            end
            ST_DECODE: begin
               ctl.alu_src_b = SRC_B_BRANCH;
               if (dec.cls == CLS_ILLEGAL) begin
                  ctl.illegal_instr = 1'b1;
                  state_d           = ST_FETCH;
               end else begin
                  state_d = ST_EXEC;
               end
            end
            ST_EXEC: begin
               ctl.alu_src_a     = dec.shift;
               ctl.ext_op        = dec.ext_op;
               ctl.lu_op         = dec.lu_op;
               ctl.alu_op[3:0]   = dec.alu_op;
               case (dec.cls)
                  CLS_BRANCH: begin
                     ctl.pc_write_cond = 1'b1;
                     ctl.pc_src        = PC_SRC_BRANCH;
                     state_d           = ST_FETCH;
                  end
                  CLS_JUMP, CLS_JAL, CLS_JR, CLS_JALR: begin
                     ctl.pc_write = 1'b1;
                     ctl.pc_src   = (dec.cls == CLS_JUMP || dec.cls == CLS_JAL) ? PC_SRC_JUMP
                                                                                 : PC_SRC_REG;
                     if (dec.cls == CLS_JAL || dec.cls == CLS_JALR) begin
                        ctl.reg_write  = 1'b1;
                        ctl.reg_dst    = REG_DST_RA;
                        ctl.mem_to_reg = M2R_LINK;
                     end
                     state_d = ST_FETCH;
                  end
                  CLS_LOAD, CLS_STORE: begin
                     ctl.alu_src_b = SRC_B_IMM;
                     ctl.ext_op    = 1'b1;
                     state_d       = ST_MEM;
                  end
                  CLS_ALU_I: begin
                     ctl.alu_src_b = SRC_B_IMM;
                     state_d       = ST_WB;
                  end
`ifdef MULTICYCLE_MULDIV_EN
                  CLS_MULDIV: begin
                     ctl.muldiv_start = 1'b1;
                     state_d          = ST_MULDIV_WAIT;
                  end
`endif
                  default: state_d = ST_WB;
               endcase
            end
            ST_MEM: begin
               ctl.i_or_d = 1'b1;
               if (dec.cls == CLS_LOAD) ctl.mem_read  = 1'b1;
               else                     ctl.mem_write = 1'b1;
               if (ctl.mem_ready)
                  state_d = (dec.cls == CLS_LOAD) ? ST_WB : ST_FETCH;
               else
                  state_d = ST_MEM;
            end
            ST_WB: begin
               ctl.reg_write = 1'b1;
               ctl.reg_dst   = writes_rd(dec.cls) ? REG_DST_RD : REG_DST_RT;
               if (dec.cls == CLS_LOAD)        ctl.mem_to_reg = M2R_MEM;
               else if (dec.cls == CLS_MFHILO) ctl.mem_to_reg = M2R_HILO;
               else                            ctl.mem_to_reg = M2R_ALU;
               state_d = ST_FETCH;
            end
`ifdef MULTICYCLE_MULDIV_EN
            ST_MULDIV_WAIT: state_d = wait_done ? ST_FETCH : ST_MULDIV_WAIT;
`endif
            default: state_d = ST_FETCH;
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: reset, ALU/jump/memory/illegal paths and reset during MEM.
// mult/mfhi expectations follow whether MULTICYCLE_MULDIV_EN is defined for the build.
module tb_multicycle_control;

   localparam int ALUOP_W       = 4;
   localparam int MULDIV_CYCLES = 4;

   logic clk = 1'b0;
   logic reset;
   int   checks   = 0;
   int   failures = 0;
   logic [2:0] exp_q[$];

   typedef struct {
      logic [5:0] op;
      logic [5:0] fn;
      logic [3:0] alu_op;
      logic       ext_op;
      logic       src_a;
      logic [1:0] src_b;
      logic       lu_op;
      logic [1:0] reg_dst;
   } alu_vec_t;

   typedef struct {
      logic [5:0] op;
      logic [5:0] fn;
      logic [1:0] pc_src;
      logic       link;
   } jmp_vec_t;

   alu_vec_t alu_vecs[8];
   jmp_vec_t jmp_vecs[4];

   multicycle_control_if #(.ALUOP_W(ALUOP_W)) ctl ();

   multicycle_control #(
      .MULDIV_CYCLES (MULDIV_CYCLES),
      .ALUOP_W       (ALUOP_W)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .ctl   (ctl)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic next_cycle();
      @(negedge clk);
      #1;
   endtask

   task automatic drive(input logic [5:0] op, input logic [5:0] fn, input logic rdy);
      ctl.opcode    = op;
      ctl.funct     = fn;
      ctl.mem_ready = rdy;
      #1;
   endtask

   task automatic step_state(input string tag);
      logic [2:0] e;
      e = exp_q.pop_front();
      check({tag, "_state"}, ctl.state, e);
   endtask

   initial begin
      #100000;
      failures++;
      $display("FAIL watchdog: time limit reached");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      //             op     fn     alu_op   ext  a    b     lu   dst
      alu_vecs[0] = '{6'h00, 6'h20, 4'b0010, 1'b1, 1'b0, 2'd0, 1'b0, 2'd1}; // add
      alu_vecs[1] = '{6'h00, 6'h00, 4'b0010, 1'b1, 1'b1, 2'd0, 1'b0, 2'd1}; // sll
      alu_vecs[2] = '{6'h00, 6'h27, 4'b0010, 1'b1, 1'b0, 2'd0, 1'b0, 2'd1}; // nor
      alu_vecs[3] = '{6'h08, 6'h00, 4'b0000, 1'b1, 1'b0, 2'd2, 1'b0, 2'd0}; // addi
      alu_vecs[4] = '{6'h0C, 6'h00, 4'b0100, 1'b0, 1'b0, 2'd2, 1'b0, 2'd0}; // andi
      alu_vecs[5] = '{6'h0A, 6'h00, 4'b0101, 1'b1, 1'b0, 2'd2, 1'b0, 2'd0}; // slti
      alu_vecs[6] = '{6'h0B, 6'h00, 4'b1101, 1'b0, 1'b0, 2'd2, 1'b0, 2'd0}; // sltiu
      alu_vecs[7] = '{6'h0F, 6'h00, 4'b1000, 1'b1, 1'b0, 2'd2, 1'b1, 2'd0}; // lui
      jmp_vecs[0] = '{6'h02, 6'h00, 2'b10, 1'b0}; // j
      jmp_vecs[1] = '{6'h03, 6'h00, 2'b10, 1'b1}; // jal
      jmp_vecs[2] = '{6'h00, 6'h08, 2'b11, 1'b0}; // jr
      jmp_vecs[3] = '{6'h00, 6'h09, 2'b11, 1'b1}; // jalr

      // Reset state with inputs that would otherwise start a fetch.
      reset = 1'b1;
      drive(6'h23, 6'h00, 1'b1);
      #1;
      check("rst_state", ctl.state, 0);
      check("rst_mem_read", ctl.mem_read, 0);
      check("rst_ir_write", ctl.ir_write, 0);
      check("rst_pc_write", ctl.pc_write, 0);
      check("rst_busy", ctl.busy, 0);
      check("rst_illegal", ctl.illegal_instr, 0);
      next_cycle();
      reset = 1'b0;

      // ALU instructions: FETCH, DECODE, EXEC, WB.
      foreach (alu_vecs[k]) begin
         drive(alu_vecs[k].op, alu_vecs[k].fn, 1'b1);
         exp_q = '{3'd0, 3'd1, 3'd2, 3'd4};
         for (int i = 0; i < 4; i++) begin
            step_state($sformatf("alu%0d_c%0d", k, i));
            check($sformatf("alu%0d_reg_write_c%0d", k, i), ctl.reg_write, (i == 3));
            check($sformatf("alu%0d_mem_write_c%0d", k, i), ctl.mem_write, 0);
            if (i == 0) begin
               check($sformatf("alu%0d_fetch_mem_read", k), ctl.mem_read, 1);
               check($sformatf("alu%0d_fetch_i_or_d", k), ctl.i_or_d, 0);
               check($sformatf("alu%0d_fetch_ir_write", k), ctl.ir_write, 1);
               check($sformatf("alu%0d_fetch_pc_write", k), ctl.pc_write, 1);
               check($sformatf("alu%0d_fetch_busy", k), ctl.busy, 0);
            end
            if (i == 1) begin
               check($sformatf("alu%0d_dec_src_a", k), ctl.alu_src_a, 0);
               check($sformatf("alu%0d_dec_src_b", k), ctl.alu_src_b, 3);
               check($sformatf("alu%0d_dec_busy", k), ctl.busy, 1);
            end
            if (i == 2) begin
               check($sformatf("alu%0d_alu_op", k), ctl.alu_op, alu_vecs[k].alu_op);
               check($sformatf("alu%0d_ext_op", k), ctl.ext_op, alu_vecs[k].ext_op);
               check($sformatf("alu%0d_src_a", k), ctl.alu_src_a, alu_vecs[k].src_a);
               check($sformatf("alu%0d_src_b", k), ctl.alu_src_b, alu_vecs[k].src_b);
               check($sformatf("alu%0d_lu_op", k), ctl.lu_op, alu_vecs[k].lu_op);
            end
            if (i == 3) begin
               check($sformatf("alu%0d_wb_reg_dst", k), ctl.reg_dst, alu_vecs[k].reg_dst);
               check($sformatf("alu%0d_wb_mem_to_reg", k), ctl.mem_to_reg, 0);
            end
            next_cycle();
         end
      end

      // lw with three wait cycles in MEM: 8 cycles in total.
      drive(6'h23, 6'h00, 1'b1);
      exp_q = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd3, 3'd4};
      for (int i = 0; i < 8; i++) begin
         ctl.mem_ready = (i == 0 || i >= 6);
         #1;
         step_state($sformatf("lw_c%0d", i));
         check($sformatf("lw_reg_write_c%0d", i), ctl.reg_write, (i == 7));
         if (i == 2) begin
            check("lw_exec_src_b", ctl.alu_src_b, 2);
            check("lw_exec_ext_op", ctl.ext_op, 1);
            check("lw_exec_alu_op", ctl.alu_op, 4'b1000);
         end
         if (i >= 3 && i <= 6) begin
            check($sformatf("lw_mem_read_c%0d", i), ctl.mem_read, 1);
            check($sformatf("lw_i_or_d_c%0d", i), ctl.i_or_d, 1);
            check($sformatf("lw_mem_write_c%0d", i), ctl.mem_write, 0);
         end
         if (i == 7) begin
            check("lw_wb_mem_to_reg", ctl.mem_to_reg, 1);
            check("lw_wb_reg_dst", ctl.reg_dst, 0);
         end
         next_cycle();
      end

      // beq: 3 cycles, conditional PC write in EXEC.
      drive(6'h04, 6'h00, 1'b1);
      exp_q = '{3'd0, 3'd1, 3'd2};
      for (int i = 0; i < 3; i++) begin
         step_state($sformatf("beq_c%0d", i));
         check($sformatf("beq_reg_write_c%0d", i), ctl.reg_write, 0);
         if (i == 2) begin
            check("beq_pc_write_cond", ctl.pc_write_cond, 1);
            check("beq_pc_write", ctl.pc_write, 0);
            check("beq_pc_src", ctl.pc_src, 2'b01);
            check("beq_alu_op", ctl.alu_op, 4'b0001);
         end
         next_cycle();
      end

      // Jumps: 3 cycles, link variants write $ra in EXEC.
      foreach (jmp_vecs[k]) begin
         drive(jmp_vecs[k].op, jmp_vecs[k].fn, 1'b1);
         exp_q = '{3'd0, 3'd1, 3'd2};
         for (int i = 0; i < 3; i++) begin
            step_state($sformatf("jmp%0d_c%0d", k, i));
            if (i == 2) begin
               check($sformatf("jmp%0d_pc_write", k), ctl.pc_write, 1);
               check($sformatf("jmp%0d_pc_src", k), ctl.pc_src, jmp_vecs[k].pc_src);
               check($sformatf("jmp%0d_reg_write", k), ctl.reg_write, jmp_vecs[k].link);
               if (jmp_vecs[k].link) begin
                  check($sformatf("jmp%0d_reg_dst", k), ctl.reg_dst, 2);
                  check($sformatf("jmp%0d_mem_to_reg", k), ctl.mem_to_reg, 2);
               end
            end else begin
               check($sformatf("jmp%0d_reg_write_c%0d", k, i), ctl.reg_write, 0);
            end
            next_cycle();
         end
      end

      // Illegal opcode, then FETCH held with mem_ready low.
      drive(6'h3F, 6'h00, 1'b1);
      exp_q = '{3'd0, 3'd1, 3'd0};
      for (int i = 0; i < 3; i++) begin
         ctl.mem_ready = (i == 0);
         #1;
         step_state($sformatf("ill_c%0d", i));
         check($sformatf("ill_pulse_c%0d", i), ctl.illegal_instr, (i == 1));
         check($sformatf("ill_reg_write_c%0d", i), ctl.reg_write, 0);
         check($sformatf("ill_mem_write_c%0d", i), ctl.mem_write, 0);
         if (i == 2) begin
            check("hold_ir_write", ctl.ir_write, 0);
            check("hold_pc_write", ctl.pc_write, 0);
            check("hold_mem_read", ctl.mem_read, 1);
         end
         next_cycle();
      end
      check("hold_still_fetch", ctl.state, 0);

`ifdef MULTICYCLE_MULDIV_EN
      drive(6'h00, 6'h18, 1'b1);
      exp_q = '{3'd0, 3'd1, 3'd2, 3'd5, 3'd5, 3'd5, 3'd5};
      for (int i = 0; i < 7; i++) begin
         step_state($sformatf("mult_c%0d", i));
         check($sformatf("mult_start_c%0d", i), ctl.muldiv_start, (i == 2));
         check($sformatf("mult_reg_write_c%0d", i), ctl.reg_write, 0);
         next_cycle();
      end
      drive(6'h00, 6'h10, 1'b1);
      exp_q = '{3'd0, 3'd1, 3'd2, 3'd4};
      for (int i = 0; i < 4; i++) begin
         step_state($sformatf("mfhi_c%0d", i));
         if (i == 3) begin
            check("mfhi_reg_write", ctl.reg_write, 1);
            check("mfhi_mem_to_reg", ctl.mem_to_reg, 3);
            check("mfhi_reg_dst", ctl.reg_dst, 1);
         end
         next_cycle();
      end
`else
      drive(6'h00, 6'h18, 1'b1);
      exp_q = '{3'd0, 3'd1};
      for (int i = 0; i < 2; i++) begin
         step_state($sformatf("mult_c%0d", i));
         check($sformatf("mult_illegal_c%0d", i), ctl.illegal_instr, (i == 1));
         check($sformatf("mult_start_c%0d", i), ctl.muldiv_start, 0);
         next_cycle();
      end
`endif

      // sw: reset arrives in MEM together with mem_ready.
      drive(6'h2B, 6'h00, 1'b1);
      exp_q = '{3'd0, 3'd1, 3'd2, 3'd3};
      for (int i = 0; i < 4; i++) begin
         ctl.mem_ready = (i == 0);
         #1;
         step_state($sformatf("sw_c%0d", i));
         if (i == 3) begin
            check("sw_mem_write", ctl.mem_write, 1);
            check("sw_i_or_d", ctl.i_or_d, 1);
            check("sw_mem_read", ctl.mem_read, 0);
         end
         if (i < 3) next_cycle();
      end
      ctl.mem_ready = 1'b1;
      reset = 1'b1;
      #1;
      check("rst_mem_write", ctl.mem_write, 0);
      check("rst_mid_state", ctl.state, 0);
      check("rst_mid_busy", ctl.busy, 0);
      check("rst_mid_reg_write", ctl.reg_write, 0);
      next_cycle();
      check("rst_held_state", ctl.state, 0);
      check("rst_held_mem_read", ctl.mem_read, 0);
      reset = 1'b0;
      #1;
      check("post_rst_state", ctl.state, 0);
      check("post_rst_mem_read", ctl.mem_read, 1);
      check("post_rst_busy", ctl.busy, 0);
      next_cycle();
      check("post_rst_decode", ctl.state, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
